gshare_branch_predictor: RTL and testbench
==========================================

// Module: gshare_branch_predictor
// PURPOSE
//  Parametrised successor to the bimodal predictor and BTB used by the processor IF/EM stages.
//  Combines a tagged BTB and a 2-bit-counter pattern history table (PHT).
//  The PHT is indexed either by PC alone (bimodal) or by PC XOR global history (gshare).
//  Predicts at IF with a 1-cycle latency; trained from EM through the feedback port.
//  Has a per-entry clearing init sequence and hit/prediction statistics.
// PARAMETERS
//  ADDR_W  32  PC/target width
//  IDX_W   10  log2 table entries (PHT and BTB share the index)
//  TAG_W    8  BTB tag width, taken from pc[2+IDX_W +: TAG_W]
//  HIST_W   8  global history length; legal range 1..IDX_W
//  MODE     1  0 = bimodal (idx = pc[2+:IDX_W]); 1 = gshare (idx = pc[2+:IDX_W] ^ {0,ghr})
// PORTS
//  clk        in   1          clock
//  rst        in   1          reset; asynchronous, active-high
//  bp_oe      in   1          lookup enable for bp_pc
//  bp_pc      in   ADDR_W     fetch PC
//  bp_taken   out  1          predicted taken
//  bp_hit     out  1          BTB valid && tag match
//  bp_target  out  ADDR_W     predicted target (BTB data)
//  bp_data    out  HIST_W+3   snapshot {ghr, hit, ctr[1:0]}; carried down the pipeline
//  fb_we      in   1          train with a resolved control transfer
//  fb_pc      in   ADDR_W     PC of the resolved instruction
//  fb_taken   in   1          actual outcome
//  fb_target  in   ADDR_W     actual target
//  fb_data    in   HIST_W+3   bp_data snapshot returned with the instruction
//  ready      out  1          initialisation complete
//  cnt_hit    out  32         correct predictions
//  cnt_pred   out  32         trained predictions
// BEHAVIOUR
//  Reset values: all outputs 0; ghr = 0; FSM = INIT at index 0.
//  FSM INIT:
//   - One entry per cycle: PHT <= 2'b01, BTB valid <= 0.
//   - After entry 2^IDX_W-1, go to RUN; ready = 1 from the next cycle.
//  FSM RUN: the terminal state; leaves only on rst.
//  During INIT:
//   - bp_taken and bp_hit are forced 0.
//   - fb_we is ignored; stats and ghr are frozen.
//   - bp_data carries ghr and zeroes.
//  Lookup (bp_oe = 1, sampled at posedge):
//   - Registered outputs update at that edge from the index computed with the current ghr.
//   - bp_oe = 0: all bp_* outputs hold their values.
//   - bp_taken = bp_hit & ctr[1].
//  Training (fb_we = 1 in RUN), with h = fb_data history and c = fb_data counter:
//   - Index is rebuilt from fb_pc and h, so exactly the predicted entry is trained.
//   - PHT[idx] <= saturating c+1 if fb_taken, else saturating c-1 (bounds 0..3).
//   - If fb_taken: BTB[idx] <= {valid = 1, fb_pc tag, fb_target}. Not-taken leaves BTB untouched.
//   - ghr <= {ghr[HIST_W-2:0], fb_taken} (non-speculative). HIST_W = 1 holds only the last outcome.
//   - cnt_pred += 1.
//   - cnt_hit += 1 when (fb_data.hit & fb_data.ctr[1]) == fb_taken.
//   - Both counters wrap modulo 2^32.
//  Lookup and training on the same index in the same cycle: read-first.
//   - The lookup returns pre-write data; no bypass.
//  Training is applied the same edge as fb_we; a lookup one cycle later sees the new data.
//  rst mid-operation, whether in RUN or INIT:
//   - Outputs, ghr and stats clear immediately.
//   - Init restarts from index 0.
//   - A pending fb_we is dropped.
// TESTING
//  1. rst pulse, IDX_W = 10 -> ready rises exactly 1024 cycles after rst deasserts (+1 registered); bp_taken = 0 throughout.
//  2. MODE = 0; pc 0x100 trained taken to 0x80, twice -> counter 01 -> 10 -> 11; next lookup bp_taken = 1, bp_target = 0x80, bp_hit = 1.
//  3. MODE = 0; 5x taken then 1x not-taken -> still taken (3 -> 2); 2 more not-taken -> bp_taken = 0 (counter 0); cnt_pred = 8.
//  4. Alias: pc 0x100 trained taken; lookup 0x1100 (same idx, different tag) -> bp_hit = 0, bp_taken = 0.
//  5. MODE = 1, HIST_W = 1; single pc alternating T/N for 20 trainings -> last 10 predictions all correct, cnt_hit increments each time.
//  6. rst during RUN with cnt_pred = 50 -> all outputs 0 asynchronously; ready = 0; after 2^IDX_W cycles, lookup of pc 0x100 gives bp_hit = 0.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: tagged BTB plus 2-bit-counter PHT, indexed by PC
// (bimodal) or PC ^ global history (gshare). One-cycle registered lookup at IF,
// non-speculative training from EM, per-entry clearing after reset, and stats.
module gshare_branch_predictor #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 10,
    parameter int TAG_W  = 8,
    parameter int HIST_W = 8,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bp_oe,
    input  logic [ADDR_W-1:0] bp_pc,
    output logic              bp_taken,
    output logic              bp_hit,
    output logic [ADDR_W-1:0] bp_target,
    output logic [HIST_W+2:0] bp_data,
    input  logic              fb_we,
    input  logic [ADDR_W-1:0] fb_pc,
    input  logic              fb_taken,
    input  logic [ADDR_W-1:0] fb_target,
    input  logic [HIST_W+2:0] fb_data,
    output logic              ready,
    output logic [31:0]       cnt_hit,
    output logic [31:0]       cnt_pred
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    init_idx_q, init_idx_d;
    logic [HIST_W-1:0]   ghr_q, ghr_d;
    logic                ready_q;
    logic [31:0]         cnt_hit_q, cnt_pred_q;
    logic                bp_taken_q, bp_hit_q;
    logic [ADDR_W-1:0]   bp_target_q;
    logic [HIST_W+2:0]   bp_data_q;

    // Tables are not reset; the INIT walk clears them one entry per cycle.
    logic [1:0]          pht_q     [ENTRIES];
    logic                btb_vld_q [ENTRIES];
    logic [TAG_W-1:0]    btb_tag_q [ENTRIES];
    logic [ADDR_W-1:0]   btb_tgt_q [ENTRIES];

    // History only folds into the index in gshare mode.
    function automatic logic [IDX_W-1:0] make_idx(input logic [ADDR_W-1:0] pc,
                                                  input logic [HIST_W-1:0] h);
        logic [IDX_W-1:0] hx;
        hx = (MODE != 0) ? IDX_W'(h) : '0;
        return pc[2 +: IDX_W] ^ hx;
    endfunction

    logic [IDX_W-1:0]  lk_idx, tr_idx;
    logic [1:0]        lk_ctr, tr_ctr, fb_ctr;
    logic              lk_hit, fb_hit, tr_en, tr_correct;
    logic [HIST_W-1:0] fb_hist;

    // Lookup read and training decode; training uses the snapshot history so
    // the entry that made the prediction is the one updated.
    always_comb begin
        lk_idx     = make_idx(bp_pc, ghr_q);
        lk_ctr     = pht_q[lk_idx];
        lk_hit     = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == bp_pc[2+IDX_W +: TAG_W]);
        fb_hist    = fb_data[HIST_W+2:3];
        fb_hit     = fb_data[2];
        fb_ctr     = fb_data[1:0];
        tr_idx     = make_idx(fb_pc, fb_hist);
        tr_en      = fb_we && (state_q == ST_RUN);
        tr_correct = ((fb_hit & fb_ctr[1]) == fb_taken);
        tr_ctr     = fb_ctr;
        if (fb_taken) begin
            if (fb_ctr != 2'b11) tr_ctr = fb_ctr + 2'd1;
        end else begin
            if (fb_ctr != 2'b00) tr_ctr = fb_ctr - 2'd1;
        end
        ghr_d = tr_en ? HIST_W'({ghr_q, fb_taken}) : ghr_q;
    end

    // Init walk: clear each entry once, then stay in RUN until reset.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == '1) state_d = ST_RUN;
        end
    end

    // Table writes: clearing during INIT, training afterwards. Reads above see
    // pre-write contents, so a same-index lookup is read-first.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            pht_q[init_idx_q]     <= 2'b01;
            btb_vld_q[init_idx_q] <= 1'b0;
            btb_tag_q[init_idx_q] <= '0;
            btb_tgt_q[init_idx_q] <= '0;
        end else if (tr_en) begin
            pht_q[tr_idx] <= tr_ctr;
            if (fb_taken) begin
                btb_vld_q[tr_idx] <= 1'b1;
                btb_tag_q[tr_idx] <= fb_pc[2+IDX_W +: TAG_W];
                btb_tgt_q[tr_idx] <= fb_target;
            end
        end
    end

    // Control state, history, stats and the registered lookup outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            ghr_q       <= '0;
            ready_q     <= 1'b0;
            cnt_hit_q   <= '0;
            cnt_pred_q  <= '0;
            bp_taken_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_target_q <= '0;
            bp_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
            ready_q    <= (state_q == ST_RUN);
            if (tr_en) begin
                cnt_pred_q <= cnt_pred_q + 32'd1;
                if (tr_correct) cnt_hit_q <= cnt_hit_q + 32'd1;
            end
            if (bp_oe) begin
                if (state_q == ST_RUN) begin
                    bp_taken_q  <= lk_hit & lk_ctr[1];
                    bp_hit_q    <= lk_hit;
                    bp_target_q <= btb_tgt_q[lk_idx];
                    bp_data_q   <= {ghr_q, lk_hit, lk_ctr};
                end else begin
                    bp_taken_q  <= 1'b0;
                    bp_hit_q    <= 1'b0;
                    bp_target_q <= '0;
                    bp_data_q   <= {ghr_q, 3'b000};
                end
            end
        end
    end

    assign bp_taken  = bp_taken_q;
    assign bp_hit    = bp_hit_q;
    assign bp_target = bp_target_q;
    assign bp_data   = bp_data_q;
    assign ready     = ready_q;
    assign cnt_hit   = cnt_hit_q;
    assign cnt_pred  = cnt_pred_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: bimodal instance (IDX_W=10) for init timing, training,
// aliasing, read-first and mid-run reset; gshare instance with HIST_W=1 for
// the alternating-pattern case.
module tb_gshare_branch_predictor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Bimodal instance
    logic        bp_oe, bp_taken, bp_hit, fb_we, fb_taken, ready;
    logic [31:0] bp_pc, bp_target, fb_pc, fb_target, cnt_hit, cnt_pred;
    logic [10:0] bp_data, fb_data;

    gshare_branch_predictor #(.ADDR_W(32), .IDX_W(10), .TAG_W(8), .HIST_W(8), .MODE(0)) dut (
        .clk(clk), .rst(rst), .bp_oe(bp_oe), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .bp_hit(bp_hit), .bp_target(bp_target), .bp_data(bp_data), .fb_we(fb_we),
        .fb_pc(fb_pc), .fb_taken(fb_taken), .fb_target(fb_target), .fb_data(fb_data),
        .ready(ready), .cnt_hit(cnt_hit), .cnt_pred(cnt_pred));

    // Gshare instance, one bit of history
    logic        g_oe, g_taken, g_hit, g_we, g_fbt, g_ready;
    logic [31:0] g_pc, g_target, g_fbpc, g_fbtgt, g_cnt_hit, g_cnt_pred;
    logic [3:0]  g_data, g_fbdata;

    gshare_branch_predictor #(.ADDR_W(32), .IDX_W(4), .TAG_W(8), .HIST_W(1), .MODE(1)) dut_g (
        .clk(clk), .rst(rst), .bp_oe(g_oe), .bp_pc(g_pc), .bp_taken(g_taken),
        .bp_hit(g_hit), .bp_target(g_target), .bp_data(g_data), .fb_we(g_we),
        .fb_pc(g_fbpc), .fb_taken(g_fbt), .fb_target(g_fbtgt), .fb_data(g_fbdata),
        .ready(g_ready), .cnt_hit(g_cnt_hit), .cnt_pred(g_cnt_pred));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        ex_hit;
        logic        ex_taken;
        logic [1:0]  ex_ctr;
        logic [31:0] ex_tgt;
        logic        train;
        logic        fb_t;
        logic [31:0] fb_tgt;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic h, logic t, logic [1:0] c,
                                logic [31:0] tg, logic tr, logic ft, logic [31:0] ftg);
        vec_t v;
        v.pc = pc; v.ex_hit = h; v.ex_taken = t; v.ex_ctr = c; v.ex_tgt = tg;
        v.train = tr; v.fb_t = ft; v.fb_tgt = ftg;
        return v;
    endfunction

    vec_t        vecs [13];
    logic [7:0]  ghr_m;
    int          pred_m, hit_m, bad;
    logic [1:0]  gpht [16];
    logic        gvld [16];
    logic        gghr;
    int          ghit_m;

    initial begin
        // pc 0x100 -> idx 0x40 tag 0; pc 0x200 -> idx 0x80; pc 0x1100 aliases 0x100 with tag 1
        vecs[0]  = mk(32'h100,  1'b0, 1'b0, 2'b01, 32'h0,   1'b1, 1'b1, 32'h80);
        vecs[1]  = mk(32'h100,  1'b1, 1'b1, 2'b10, 32'h80,  1'b1, 1'b1, 32'h80);
        vecs[2]  = mk(32'h100,  1'b1, 1'b1, 2'b11, 32'h80,  1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(32'h200,  1'b0, 1'b0, 2'b01, 32'h0,   1'b1, 1'b1, 32'h300);
        vecs[4]  = mk(32'h200,  1'b1, 1'b1, 2'b10, 32'h300, 1'b1, 1'b1, 32'h300);
        vecs[5]  = mk(32'h200,  1'b1, 1'b1, 2'b11, 32'h300, 1'b1, 1'b1, 32'h300);
        vecs[6]  = mk(32'h200,  1'b1, 1'b1, 2'b11, 32'h300, 1'b1, 1'b1, 32'h300);
        vecs[7]  = mk(32'h200,  1'b1, 1'b1, 2'b11, 32'h300, 1'b1, 1'b1, 32'h300);
        vecs[8]  = mk(32'h200,  1'b1, 1'b1, 2'b11, 32'h300, 1'b1, 1'b0, 32'h0);
        vecs[9]  = mk(32'h200,  1'b1, 1'b1, 2'b10, 32'h300, 1'b1, 1'b0, 32'h0);
        vecs[10] = mk(32'h200,  1'b1, 1'b0, 2'b01, 32'h300, 1'b1, 1'b0, 32'h0);
        vecs[11] = mk(32'h200,  1'b1, 1'b0, 2'b00, 32'h300, 1'b0, 1'b0, 32'h0);
        vecs[12] = mk(32'h1100, 1'b0, 1'b0, 2'b11, 32'h80,  1'b0, 1'b0, 32'h0);

        rst = 1'b1;
        bp_oe = 1'b0; bp_pc = '0; fb_we = 1'b0; fb_pc = '0; fb_taken = 1'b0;
        fb_target = '0; fb_data = '0;
        g_oe = 1'b0; g_pc = '0; g_we = 1'b0; g_fbpc = '0; g_fbt = 1'b0;
        g_fbtgt = '0; g_fbdata = '0;
        ghr_m = '0; pred_m = 0; hit_m = 0;

        repeat (2) tick();
        chk("rst_taken", bp_taken, 1'b0);
        chk("rst_hit", bp_hit, 1'b0);
        chk("rst_target", bp_target, 32'h0);
        chk("rst_data", bp_data, 11'h0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_cnt_pred", cnt_pred, 32'h0);

        // Init timing: ready rises on the 1025th edge after reset release
        rst = 1'b0;
        bp_oe = 1'b1; bp_pc = 32'h100;
        bad = 0;
        for (int k = 1; k <= 1025; k++) begin
            tick();
            if (bp_taken !== 1'b0) bad++;
            if (k == 1024) chk("ready_at_1024", ready, 1'b0);
            if (k == 1025) chk("ready_at_1025", ready, 1'b1);
        end
        chk("init_taken_zero", bad, 0);
        bp_oe = 1'b0;

        // Table: lookup, check, then train with the returned snapshot
        for (int i = 0; i < 13; i++) begin
            bp_oe = 1'b1; bp_pc = vecs[i].pc;
            tick();
            bp_oe = 1'b0;
            chk($sformatf("row%0d_hit", i), bp_hit, vecs[i].ex_hit);
            chk($sformatf("row%0d_taken", i), bp_taken, vecs[i].ex_taken);
            chk($sformatf("row%0d_target", i), bp_target, vecs[i].ex_tgt);
            chk($sformatf("row%0d_data", i), bp_data, {ghr_m, vecs[i].ex_hit, vecs[i].ex_ctr});
            if (vecs[i].train) begin
                fb_we = 1'b1; fb_pc = vecs[i].pc; fb_taken = vecs[i].fb_t;
                fb_target = vecs[i].fb_tgt; fb_data = bp_data;
                tick();
                fb_we = 1'b0;
                pred_m++;
                if ((vecs[i].ex_hit & vecs[i].ex_ctr[1]) == vecs[i].fb_t) hit_m++;
                ghr_m = {ghr_m[6:0], vecs[i].fb_t};
                chk($sformatf("row%0d_cnt_pred", i), cnt_pred, pred_m);
                chk($sformatf("row%0d_cnt_hit", i), cnt_hit, hit_m);
            end
        end

        // bp_oe low holds every lookup output
        bp_oe = 1'b1; bp_pc = 32'h100;
        tick();
        bp_oe = 1'b0; bp_pc = 32'h200;
        tick();
        chk("hold_taken", bp_taken, 1'b1);
        chk("hold_target", bp_target, 32'h80);
        chk("hold_data", bp_data, {ghr_m, 1'b1, 2'b11});

        // Same-index lookup and training in one cycle: lookup sees old data
        bp_oe = 1'b1; bp_pc = 32'h400;
        fb_we = 1'b1; fb_pc = 32'h400; fb_taken = 1'b1; fb_target = 32'h500;
        fb_data = {ghr_m, 1'b0, 2'b01};
        tick();
        fb_we = 1'b0;
        chk("rf_hit_old", bp_hit, 1'b0);
        chk("rf_data_old", bp_data, {ghr_m, 1'b0, 2'b01});
        pred_m++;
        ghr_m = {ghr_m[6:0], 1'b1};
        tick();
        bp_oe = 1'b0;
        chk("rf_hit_new", bp_hit, 1'b1);
        chk("rf_taken_new", bp_taken, 1'b1);
        chk("rf_target_new", bp_target, 32'h500);
        chk("rf_data_new", bp_data, {ghr_m, 1'b1, 2'b10});
        chk("rf_cnt_pred", cnt_pred, pred_m);
        chk("rf_cnt_hit", cnt_hit, hit_m);

        // Gshare, HIST_W=1: one pc alternating T/N; entries 0 and 1 separate it
        chk("g_ready", g_ready, 1'b1);
        for (int e = 0; e < 16; e++) begin gpht[e] = 2'b01; gvld[e] = 1'b0; end
        gghr = 1'b0; ghit_m = 0;
        for (int i = 0; i < 20; i++) begin
            logic t, eh;
            logic [1:0] ec;
            int idx;
            t = (i % 2 == 0);
            idx = int'(gghr);
            eh = gvld[idx]; ec = gpht[idx];
            g_oe = 1'b1; g_pc = 32'h0;
            tick();
            g_oe = 1'b0;
            chk($sformatf("g%0d_data", i), g_data, {gghr, eh, ec});
            chk($sformatf("g%0d_taken", i), g_taken, eh & ec[1]);
            if (i >= 10) chk($sformatf("g%0d_correct", i), g_taken, t);
            g_we = 1'b1; g_fbpc = 32'h0; g_fbt = t; g_fbtgt = 32'h40; g_fbdata = g_data;
            tick();
            g_we = 1'b0;
            if ((eh & ec[1]) == t) ghit_m++;
            if (t) begin
                gvld[idx] = 1'b1;
                if (ec != 2'b11) gpht[idx] = ec + 2'd1;
            end else if (ec != 2'b00) gpht[idx] = ec - 2'd1;
            gghr = t;
            if (i >= 10) chk($sformatf("g%0d_cnt_hit", i), g_cnt_hit, ghit_m);
        end
        chk("g_cnt_hit_final", g_cnt_hit, 32'd19);
        chk("g_cnt_pred_final", g_cnt_pred, 32'd20);

        // Mid-run reset clears outputs and stats without waiting for an edge
        #3 rst = 1'b1;
        #1;
        chk("mrst_taken", bp_taken, 1'b0);
        chk("mrst_hit", bp_hit, 1'b0);
        chk("mrst_target", bp_target, 32'h0);
        chk("mrst_data", bp_data, 11'h0);
        chk("mrst_ready", ready, 1'b0);
        chk("mrst_cnt_pred", cnt_pred, 32'h0);
        chk("mrst_cnt_hit", cnt_hit, 32'h0);
        tick();
        #2 rst = 1'b0;

        // During re-init, lookups are forced off and training is ignored
        bp_oe = 1'b1; bp_pc = 32'h100;
        fb_we = 1'b1; fb_pc = 32'h100; fb_taken = 1'b1; fb_target = 32'h80;
        fb_data = {8'h00, 1'b1, 2'b11};
        bad = 0;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            if (bp_taken !== 1'b0 || bp_hit !== 1'b0) bad++;
        end
        fb_we = 1'b0;
        chk("reinit_forced_off", bad, 0);
        chk("reinit_cnt_pred", cnt_pred, 32'h0);
        chk("reinit_ready_low", ready, 1'b0);
        tick();
        bp_oe = 1'b0;
        chk("reinit_ready", ready, 1'b1);
        chk("reinit_hit", bp_hit, 1'b0);
        chk("reinit_data", bp_data, {8'h00, 1'b0, 2'b01});
        chk("reinit_cnt_hit", cnt_hit, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
